// File: rtl/bsg_reduce_rr_sched_pkg.sv
// Shared types and helpers for the round-robin reduction scheduler.
// The optional beat counter in the top level is enabled by BSG_REDUCE_RR_SCHED_BEAT_COUNT_EN.
package bsg_reduce_rr_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_XOR = 2'd0,
      OP_AND = 2'd1,
      OP_OR  = 2'd2
   } op_e;

   function automatic logic op_identity(input op_e op);
      return (op == OP_AND);
   endfunction

   function automatic logic op_apply(input op_e op, input logic a, input logic b);
      logic r;
      unique case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         default: r = a ^ b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bsg_reduce_rr_sched_arb.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module bsg_reduce_rr_sched_arb #(
   parameter int num_req_p = 4,
   parameter int id_w      = $clog2(num_req_p)
) (
   input  logic [num_req_p-1:0] v_i,
   input  logic [id_w-1:0]      ptr_i,
   output logic [num_req_p-1:0] grant_oh_o,
   output logic [id_w-1:0]      grant_idx_o,
   output logic                 grant_v_o
);

   int idx;

   always_comb begin
      grant_oh_o  = '0;
      grant_idx_o = '0;
      grant_v_o   = 1'b0;
      idx         = 0;
      for (int i = 0; i < num_req_p; i++) begin
         idx = (int'(ptr_i) + i) % num_req_p;
         if (!grant_v_o && v_i[idx]) begin
            grant_v_o   = 1'b1;
            grant_idx_o = id_w'(idx);
         end
      end
      if (grant_v_o) begin
         grant_oh_o[grant_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/bsg_reduce_rr_sched.sv
// Round-robin shared parity/AND/OR packet reducer with a valid/yumi result channel.
// Define BSG_REDUCE_RR_SCHED_BEAT_COUNT_EN to add max_beats_p and a saturating beats_o output.
module bsg_reduce_rr_sched
   import bsg_reduce_rr_sched_pkg::*;
#(
   parameter int num_req_p = 4,
   parameter int width_p   = 16,
   parameter int op_p      = 0
`ifdef BSG_REDUCE_RR_SCHED_BEAT_COUNT_EN
  ,parameter int max_beats_p = 16
`endif
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [num_req_p-1:0]           v_i,
   input  logic [num_req_p*width_p-1:0]   data_i,
   input  logic [num_req_p-1:0]           last_i,
   output logic [num_req_p-1:0]           yumi_o,
   output logic                           v_o,
   output logic                           data_o,
   output logic [$clog2(num_req_p)-1:0]   id_o,
   input  logic                           yumi_i
`ifdef BSG_REDUCE_RR_SCHED_BEAT_COUNT_EN
  ,output logic [$clog2(max_beats_p+1)-1:0] beats_o
`endif
);

   localparam int  id_w  = $clog2(num_req_p);
   localparam op_e op_lp = op_e'(op_p[1:0]);

   if (op_p < 0 || op_p > 2) begin : g_bad_op
      $error("bsg_reduce_rr_sched: op_p must be 0 (XOR), 1 (AND) or 2 (OR)");
   end

   state_e            state_q, state_d;
   logic [id_w-1:0]   owner_q, owner_d;
   logic [id_w-1:0]   ptr_q, ptr_d;
   logic              acc_q, acc_d;

   logic [num_req_p-1:0] grant_oh;
   logic [id_w-1:0]      grant_idx;
   logic                 grant_v;

   logic [id_w-1:0]    sel_idx;
   logic [width_p-1:0] beat;
   logic               beat_last;
   logic               beat_red;

   bsg_reduce_rr_sched_arb #(
      .num_req_p (num_req_p),
      .id_w      (id_w)
   ) arb (
      .v_i         (v_i),
      .ptr_i       (ptr_q),
      .grant_oh_o  (grant_oh),
      .grant_idx_o (grant_idx),
      .grant_v_o   (grant_v)
   );

   // In IDLE the beat comes from the fresh grant; afterwards from the locked owner.
   assign sel_idx   = (state_q == IDLE) ? grant_idx : owner_q;
   assign beat      = data_i[int'(sel_idx)*width_p +: width_p];
   assign beat_last = last_i[sel_idx];

   always_comb begin
      unique case (op_lp)
         OP_AND:  beat_red = &beat;
         OP_OR:   beat_red = |beat;
         default: beat_red = ^beat;
      endcase
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      acc_d   = acc_q;
      yumi_o  = '0;
      unique case (state_q)
         IDLE: begin
            if (grant_v) begin
               yumi_o  = grant_oh;
               owner_d = grant_idx;
               acc_d   = op_apply(op_lp, op_identity(op_lp), beat_red);
               state_d = beat_last ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (v_i[owner_q]) begin
               yumi_o[owner_q] = 1'b1;
               acc_d           = op_apply(op_lp, acc_q, beat_red);
               if (beat_last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (yumi_i) begin
               ptr_d   = (owner_q == id_w'(num_req_p - 1)) ? '0 : owner_q + id_w'(1);
               acc_d   = op_identity(op_lp);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Nothing may be accepted while reset discards the transaction in flight.
      if (reset_i) begin
         yumi_o = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         acc_q   <= op_identity(op_lp);
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         acc_q   <= acc_d;
      end
   end

   assign v_o    = (state_q == DONE);
   assign data_o = v_o & acc_q;
   assign id_o   = owner_q;

`ifdef BSG_REDUCE_RR_SCHED_BEAT_COUNT_EN
   localparam int cnt_w = $clog2(max_beats_p + 1);

   logic [cnt_w-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && grant_v) begin
         cnt_d = cnt_w'(1);
      end else if (state_q == BUSY && v_i[owner_q] && cnt_q != cnt_w'(max_beats_p)) begin
         cnt_d = cnt_q + cnt_w'(1);
      end else if (state_q == DONE && yumi_i) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign beats_o = cnt_q;
`endif

   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
